// File: rtl/block_scheduler_pkg.sv
// Shared types and helpers for the kernel block scheduler.
package block_scheduler_pkg;
  localparam int DATA_W    = 32;
  localparam int MAX_CORES = 64;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} sched_state_e;
  typedef enum logic [1:0] {C_RST, C_READY, C_RUN} core_state_e;

  function automatic int unsigned popcount(input logic [MAX_CORES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CORES; i++) n = n + {31'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/block_scheduler_core.sv
// Per-core lane: reset window, ready, run; holds the block ID it was handed.
module block_scheduler_core
  import block_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int CORE_RESET_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  grant,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] id_in,
  output logic                  is_ready,
  output logic                  core_start,
  output logic                  core_reset,
  output logic [DATA_WIDTH-1:0] block_id
);
  localparam int CW = $clog2(CORE_RESET_CYCLES + 1);

  core_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= C_RST;
      cnt      <= CW'(CORE_RESET_CYCLES);
      block_id <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) block_id <= id_in;
    end
  end

  // hold parks the lane in its reset window with a full count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (hold) begin
      state_nxt = C_RST;
      cnt_nxt   = CW'(CORE_RESET_CYCLES);
    end else begin
      case (state)
        C_RST: begin
          if (cnt == CW'(1)) state_nxt = C_READY;
          else               cnt_nxt   = cnt - CW'(1);
        end
        C_READY: if (grant) state_nxt = C_RUN;
        C_RUN: begin
          if (done) begin
            state_nxt = C_RST;
            cnt_nxt   = CW'(CORE_RESET_CYCLES);
          end
        end
        default: begin
          state_nxt = C_RST;
          cnt_nxt   = CW'(CORE_RESET_CYCLES);
        end
      endcase
    end
  end

  assign is_ready   = (state == C_READY);
  assign core_start = (state == C_RUN);
  assign core_reset = (state == C_RST);
endmodule

// File: rtl/block_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);
  always_comb begin
    int j;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!grant_valid && req[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = PW'(j);
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/block_scheduler.sv
// Kernel block scheduler: accepts a launch, deals block IDs round-robin to cores.
module block_scheduler
  import block_scheduler_pkg::*;
#(
  parameter int NUM_CORES         = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int CORE_RESET_CYCLES = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 launch_valid,
  output logic                                 launch_ready,
  input  logic [DATA_WIDTH-1:0]                launch_num_blocks,
  input  logic                                 abort,
  input  logic [NUM_CORES-1:0]                 core_done,
  output logic [NUM_CORES-1:0]                 core_start,
  output logic [NUM_CORES-1:0]                 core_reset,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_block_id,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 aborted,
  output logic [DATA_WIDTH-1:0]                blocks_done_count
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_e          state, state_nxt;
  logic [DATA_WIDTH-1:0] num_blocks, dispatched, blocks_done, done_sum;
  logic [PW-1:0]         rr_ptr, grant_idx;
  logic [NUM_CORES-1:0]  is_ready, req, grant, fin;
  logic                  aborted_q, accept, run_ok, more, hold, grant_valid;

  assign accept   = (state == IDLE) && launch_valid;
  // An abort (this cycle or pending) freezes dispatch and completion counting.
  assign run_ok   = (state == RUN) && !aborted_q && !abort;
  assign hold     = !run_ok;
  assign more     = dispatched < num_blocks;
  assign req      = is_ready & {NUM_CORES{run_ok && more}};
  assign fin      = core_done & core_start & {NUM_CORES{run_ok}};
  assign done_sum = blocks_done + DATA_WIDTH'(popcount(MAX_CORES'(fin)));

  rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_arb (
    .req        (req),
    .ptr        (rr_ptr),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    block_scheduler_core #(
      .DATA_WIDTH       (DATA_WIDTH),
      .CORE_RESET_CYCLES(CORE_RESET_CYCLES)
    ) u_core (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .grant     (grant[g]),
      .done      (core_done[g]),
      .id_in     (dispatched),
      .is_ready  (is_ready[g]),
      .core_start(core_start[g]),
      .core_reset(core_reset[g]),
      .block_id  (core_block_id[g])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (launch_valid) state_nxt = RUN;
      RUN: begin
        if (aborted_q)                    state_nxt = FINISH;
        else if (!abort && done_sum == num_blocks) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      num_blocks  <= '0;
      dispatched  <= '0;
      blocks_done <= '0;
      rr_ptr      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        num_blocks  <= launch_num_blocks;
        dispatched  <= '0;
        blocks_done <= '0;
        rr_ptr      <= '0;
        aborted_q   <= 1'b0;
      end
      if (state == RUN && abort) aborted_q <= 1'b1;
      if (run_ok) blocks_done <= done_sum;
      if (grant_valid) begin
        dispatched <= dispatched + DATA_WIDTH'(1);
        rr_ptr     <= (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + PW'(1);
      end
    end
  end

  assign launch_ready      = (state == IDLE);
  assign busy              = (state != IDLE);
  assign done              = (state == FINISH);
  assign aborted           = aborted_q;
  assign blocks_done_count = blocks_done;
endmodule

// File: tb/tb_block_scheduler.sv
// Scoreboard bench: stimulus pushes expected dispatches/completions, a monitor pops them.
module tb_block_scheduler;
  localparam int NC = 4;
  localparam int DW = 32;

  typedef struct { int core; int id; int cyc; } disp_t;
  typedef struct { bit ab; int cnt; int cyc; } done_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                   launch_valid = 1'b0, abort = 1'b0;
  logic [DW-1:0]          launch_num_blocks = '0;
  logic [NC-1:0]          core_done, auto_done = '0, man_done = '0;
  logic                   launch_ready, busy, done, aborted;
  logic [NC-1:0]          core_start, core_reset;
  logic [NC-1:0][DW-1:0]  core_block_id;
  logic [DW-1:0]          blocks_done_count;
  assign core_done = auto_done | man_done;

  logic                   launch_valid3 = 1'b0;
  logic [DW-1:0]          num3 = '0;
  logic [NC-1:0]          core_done3 = '0;
  logic                   launch_ready3, busy3, done3, aborted3;
  logic [NC-1:0]          core_start3, core_reset3;
  logic [NC-1:0][DW-1:0]  core_block_id3;
  logic [DW-1:0]          count3;

  block_scheduler #(.NUM_CORES(NC), .DATA_WIDTH(DW), .CORE_RESET_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .launch_valid(launch_valid), .launch_ready(launch_ready),
    .launch_num_blocks(launch_num_blocks), .abort(abort), .core_done(core_done),
    .core_start(core_start), .core_reset(core_reset), .core_block_id(core_block_id),
    .busy(busy), .done(done), .aborted(aborted), .blocks_done_count(blocks_done_count));

  block_scheduler #(.NUM_CORES(NC), .DATA_WIDTH(DW), .CORE_RESET_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .launch_valid(launch_valid3), .launch_ready(launch_ready3),
    .launch_num_blocks(num3), .abort(1'b0), .core_done(core_done3),
    .core_start(core_start3), .core_reset(core_reset3), .core_block_id(core_block_id3),
    .busy(busy3), .done(done3), .aborted(aborted3), .blocks_done_count(count3));

  int    cyc = 0, acc_cyc = 0, n_cmp = 0, n_err = 0;
  bit    auto_en = 1'b0;
  disp_t q_disp[$];
  done_t q_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: each started block finishes 5 cycles after core_start rises.
  int st[NC];
  bit started[NC];
  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (core_start[k] && !started[k]) begin started[k] = 1'b1; st[k] = cyc; end
      else if (!core_start[k]) started[k] = 1'b0;
      auto_done[k] = auto_en && core_start[k] && started[k] && (cyc - st[k] == 5);
    end
  end

  logic [NC-1:0] prev_start = '0;
  always @(negedge clk) begin
    disp_t e;
    done_t d;
    for (int k = 0; k < NC; k++) begin
      if (core_start[k] && !prev_start[k]) begin
        n_cmp++;
        if (q_disp.size() == 0) begin
          n_err++;
          $display("FAIL dispatch_unexpected: core=%0d id=%0d cyc=%0d", k, core_block_id[k], cyc - acc_cyc);
        end else begin
          e = q_disp.pop_front();
          if (k != e.core || int'(core_block_id[k]) != e.id || cyc - acc_cyc != e.cyc) begin
            n_err++;
            $display("FAIL dispatch: got core=%0d id=%0d cyc=%0d, want core=%0d id=%0d cyc=%0d",
                     k, core_block_id[k], cyc - acc_cyc, e.core, e.id, e.cyc);
          end
        end
      end
    end
    prev_start = core_start;
    if (done) begin
      n_cmp++;
      if (q_done.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: aborted=%0b count=%0d cyc=%0d", aborted, blocks_done_count, cyc - acc_cyc);
      end else begin
        d = q_done.pop_front();
        if (aborted != d.ab || int'(blocks_done_count) != d.cnt || cyc - acc_cyc != d.cyc) begin
          n_err++;
          $display("FAIL done: got aborted=%0b count=%0d cyc=%0d, want aborted=%0b count=%0d cyc=%0d",
                   aborted, blocks_done_count, cyc - acc_cyc, d.ab, d.cnt, d.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'hF);
    chk({tag, "_core_start"}, 64'(core_start), 64'h0);
    chk({tag, "_block_id_nz"}, {63'b0, core_block_id != '0}, 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_done"}, 64'(done), 64'h0);
    chk({tag, "_aborted"}, 64'(aborted), 64'h0);
    chk({tag, "_count"}, 64'(blocks_done_count), 64'h0);
    chk({tag, "_launch_ready"}, 64'(launch_ready), 64'h1);
  endtask

  // Round-robin order with 5-cycle blocks and R=1: each core restarts every 8 cycles.
  task automatic push_disp(input int nb);
    for (int b = 0; b < nb; b++) q_disp.push_back('{b % NC, b, 3 + (b / NC) * 8 + (b % NC)});
  endtask

  task automatic launch(input int n);
    launch_valid      = 1'b1;
    launch_num_blocks = DW'(n);
    acc_cyc           = cyc;
    chk("launch_ready", 64'(launch_ready), 64'h1);
    @(negedge clk);
    launch_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    chk({nm, "_idle"}, 64'(busy), 64'h0);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_held");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_rel");

    // basic: 6 blocks over 4 cores
    auto_en = 1'b1;
    push_disp(6);
    q_done.push_back('{1'b0, 6, 18});
    launch(6);
    wait_idle("basic");

    // all four cores complete on the same edge
    auto_en = 1'b0;
    push_disp(4);
    q_done.push_back('{1'b0, 4, 7});
    launch(4);
    t = 0;
    while (core_start != 4'hF && t < 50) begin @(negedge clk); t++; end
    chk("simul_all_started", 64'(core_start), 64'hF);
    chk("simul_count_before", 64'(blocks_done_count), 64'h0);
    man_done = 4'hF;
    @(negedge clk);
    man_done = 4'h0;
    chk("simul_count_after", 64'(blocks_done_count), 64'h4);
    wait_idle("simul");

    // zero-block kernel
    q_done.push_back('{1'b0, 0, 2});
    launch(0);
    for (int i = 0; i < 3; i++) begin
      chk("zero_no_start", 64'(core_start), 64'h0);
      @(negedge clk);
    end
    wait_idle("zero");

    // core_done on cores in reset window / ready is ignored
    auto_en = 1'b1;
    push_disp(1);
    q_done.push_back('{1'b0, 1, 9});
    launch(1);
    man_done = 4'hF;
    @(negedge clk);
    @(negedge clk);
    man_done = 4'b1110;
    repeat (3) @(negedge clk);
    man_done = 4'h0;
    chk("spur_count", 64'(blocks_done_count), 64'h0);
    chk("spur_ready_cores", 64'(core_reset), 64'h0);
    wait_idle("spur");

    // abort at cycle 20 of a 100-block kernel
    push_disp(10);
    q_done.push_back('{1'b1, 8, 22});
    launch(100);
    t = 0;
    while (cyc - acc_cyc < 20 && t < 50) begin @(negedge clk); t++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_start_off", 64'(core_start), 64'h0);
    chk("abort_cores_rst", 64'(core_reset), 64'hF);
    @(negedge clk);
    chk("abort_busy_at_done", 64'(busy), 64'h1);
    @(negedge clk);
    chk("abort_launch_ready", 64'(launch_ready), 64'h1);

    // R=3 instance: first core_start five cycles after accept
    begin
      int a3;
      launch_valid3 = 1'b1;
      num3 = DW'(1);
      a3 = cyc;
      @(negedge clk);
      launch_valid3 = 1'b0;
      t = 0;
      while (!core_start3[0] && t < 20) begin @(negedge clk); t++; end
      chk("r3_first_start", 64'(cyc - a3), 64'd5);
    end

    // reset mid-kernel, then relaunch
    push_disp(4);
    launch(100);
    t = 0;
    while (cyc - acc_cyc < 9 && t < 50) begin @(negedge clk); t++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("midrst");
    push_disp(2);
    q_done.push_back('{1'b0, 2, 10});
    launch(2);
    wait_idle("relaunch");
    repeat (2) @(negedge clk);

    chk("disp_queue_drained", 64'(q_disp.size()), 64'h0);
    chk("done_queue_drained", 64'(q_done.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/block_scheduler.md
# block_scheduler

Next-generation kernel block scheduler for the GPU top level. It accepts a kernel launch over a valid/ready handshake and hands out block IDs to `NUM_CORES` compute cores. Dispatch is round-robin, at most one block per cycle, with a configurable per-core reset window. It counts completions correctly when several cores finish in the same cycle, supports abort, and completes zero-block kernels cleanly. It replaces the start-level dispatcher between kernel-config registers and the core array.

## Interface
- `NUM_CORES`, 4, number of cores served (≥1)
- `DATA_WIDTH`, 32, width of block counts and block IDs
- `CORE_RESET_CYCLES`, 1, cycles `core_reset` is held before a core becomes ready (≥1)
- `clk` in 1, clock
- `reset` in 1, synchronous, active-high
- `launch_valid` in 1, launch request
- `launch_ready` out 1, high only in IDLE
- `launch_num_blocks` in DATA_WIDTH, block count; sampled on accept
- `abort` in 1, cancel the running kernel
- `core_done` in NUM_CORES, per-core block finished
- `core_start` out NUM_CORES, per-core run enable
- `core_reset` out NUM_CORES, per-core reset
- `core_block_id` out NUM_CORES×DATA_WIDTH, block ID of each core
- `busy` out 1, kernel in progress
- `done` out 1, one-cycle completion pulse
- `aborted` out 1, qualifies `done`: 1 means the kernel was cancelled
- `blocks_done_count` out DATA_WIDTH, completed blocks for the current kernel

## Operation
- **Top FSM states:** IDLE, RUN, FINISH.
- **IDLE**
  - Outputs: `core_reset`=all 1, `core_start`=0, `busy`=0.
  - Accept when `launch_valid && launch_ready`.
  - On accept: latch `num_blocks`, clear counters and the RR pointer, go to RUN.
- **Per-core FSM states:** C_RST, C_READY, C_RUN.
  - C_RST: holds `core_reset`=1 for `CORE_RESET_CYCLES` cycles via a per-core down-counter, then goes to C_READY.
  - C_READY: `core_reset`=0, `core_start`=0.
  - C_RUN: `core_start`=1.
- **Dispatch**
  - Only in RUN, and only while `dispatched < num_blocks`.
  - `rr_arbiter` picks one C_READY core, starting at the RR pointer.
  - The granted core gets `core_block_id`←`dispatched` and goes to C_RUN; `dispatched`++.
  - The pointer moves to grant+1, mod NUM_CORES.
- **Completion**
  - A core in C_RUN with `core_done`=1 returns to C_RST.
  - `blocks_done` += popcount of all such completions in that cycle.
  - `core_done` is ignored for cores in C_RST or C_READY.
- **Finish:** when `blocks_done` + this cycle's popcount == `num_blocks`, go to FINISH. FINISH pulses `done`=1, `aborted`=0, then returns to IDLE.
- **Zero blocks:** `num_blocks`==0 goes RUN→FINISH on the first RUN cycle. No `core_start` is ever asserted.
- **Abort** (in RUN): all cores go to C_RST, `core_start`=0, then FINISH with `aborted`=1. The counters keep their values until the next accept. Abort in IDLE or FINISH is ignored.
- **Width rules:** counters are DATA_WIDTH unsigned. `num_blocks` ≤ 2^DATA_WIDTH−1. No wrap is possible, because `dispatched` stops at `num_blocks`.

## Timing
- **Reset values:** `core_reset`=all 1, `core_start`=0, `core_block_id`=0, `busy`=0, `done`=0, `aborted`=0, `blocks_done_count`=0, `launch_ready`=1 from the first cycle after reset. All outputs are registered except `launch_ready`, which is decoded from state.
- **Launch latency:** accept at edge 0; `busy`=1 and all `core_reset`=1 for cycles 1..R (R = `CORE_RESET_CYCLES`); cycle R+1 `core_reset`=0 (READY), grant core 0; cycle R+2 `core_start[0]`=1. Later grants go one per cycle, so `core_start[k]` rises at R+2+k.
- **Block turnaround:** `core_done` seen at edge t gives `core_start`=0 and `core_reset`=1 from t+1. The core is eligible again at t+1+R.
- **Done timing:** `done` rises the cycle after the final completion or abort, with `busy` still 1. The next cycle has `busy`=0 and `launch_ready`=1. Back-to-back launch is possible two cycles after the last `core_done`.
- **Same-edge events:** completion and dispatch on the same edge are both applied. A completing core cannot be re-granted until it has passed through C_RST.
- **Reset mid-kernel:** return to reset values on the next edge. Any in-flight kernel is discarded and no `done` is issued.

## Structure
- `common.svh` package additions: `sched_state_e` {IDLE, RUN, FINISH} and `core_state_e` {C_RST, C_READY, C_RUN}. Existing `data_t` is reused.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, pointer.
  - Outputs: one-hot `grant`, `grant_idx`, `grant_valid`.
  - Purely combinational.
- Popcount is a function in the package.

## Test plan
- **Basic:** NUM_CORES=4, R=1, 6 blocks, cores finish 5 cycles after start. Block IDs 0..5 are issued in round-robin order 0,1,2,3,0,1 (cores 0 and 1 receive their second blocks as they return). `done`=1 exactly once, `aborted`=0, `blocks_done_count`=6.
- **Simultaneous completion:** 4 blocks, all four `core_done` asserted on the same cycle. `blocks_done_count` jumps 0→4 and `done` pulses on the next cycle.
- **Zero blocks:** launch with 0 blocks. `done` pulses 2 cycles after accept and `core_start` stays 0 throughout.
- **Abort:** 100 blocks, abort asserted at cycle 20. All `core_start` are 0 at cycle 21, `done`=`aborted`=1 at cycle 22, and `launch_ready`=1 at cycle 23.
- **Spurious done and reset window:** `core_done` driven on READY cores is ignored. With R=3 the first `core_start` appears at cycle 5.
- **Reset mid-kernel, then relaunch:** reset asserted mid-kernel returns all outputs to reset values with no `done`. A relaunch of 2 blocks then gives block IDs 0 and 1 on cores 0 and 1.
